scan_ctrl: RTL

//  Sequences a 2-D (x,y) sweep over a rectangular region. Emits one coordinate/linear-address

---
 rtl/scan_ctrl_pkg.sv | 11 +
 rtl/scan_axis.sv | 42 ++++
 rtl/scan_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types for the 2-D scan sequencer.
// Optional build macro SCAN_CTRL_CONT_EN (continuous sweep) is consumed in scan_ctrl.sv.
package scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_axis.sv
// Single wrap counter for one scan axis: counts 0..MAX and wraps to 0.
// wrap is combinational so the next axis can chain its increment off it.
module scan_axis #(
    parameter int MAX   = 3,
    parameter int WIDTH = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] val,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] val_reg;
    logic [WIDTH-1:0] val_next;

    assign wrap = (val_reg == MAX_V);
    assign val  = val_reg;

    // clr wins over inc so an abort can never leak a stale increment
    always_comb begin
        val_next = val_reg;
        if (clr) begin
            val_next = '0;
        end else if (inc) begin
            val_next = wrap ? '0 : val_reg + ONE_V;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            val_reg <= '0;
        end else begin
            val_reg <= val_next;
        end
    end

endmodule

// File: rtl/scan_ctrl.sv
// 2-D (x,y) sweep sequencer emitting one beat per valid/ready transfer.
// Define SCAN_CTRL_CONT_EN to add the cont input for back-to-back sweeps without a bubble.
module scan_ctrl #(
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int X_WIDTH    = $clog2(X_MAX + 1),
    parameter int Y_WIDTH    = $clog2(Y_MAX + 1),
    parameter int ADDR_WIDTH = $clog2((X_MAX + 1) * (Y_MAX + 1))
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  ready,
`ifdef SCAN_CTRL_CONT_EN
    input  logic                  cont,
`endif
    output logic                  valid,
    output logic [X_WIDTH-1:0]    x,
    output logic [Y_WIDTH-1:0]    y,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_x,
    output logic                  last_y,
    output logic                  busy,
    output logic                  done
);

    import scan_ctrl_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    scan_state_t           state_reg;
    scan_state_t           state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  done_reg;
    logic                  done_next;
    logic                  cont_en;
    logic                  xfer;
    logic                  step;
    logic                  final_beat;
    logic                  clr;
    logic                  x_wrap;
    logic                  y_wrap;

`ifdef SCAN_CTRL_CONT_EN
    assign cont_en = cont;
`else
    assign cont_en = 1'b0;
`endif

    assign xfer       = valid && ready;
    assign step       = xfer && !abort;
    assign final_beat = x_wrap && y_wrap;
    assign clr        = (state_reg != RUN) || abort;

    scan_axis #(.MAX(X_MAX), .WIDTH(X_WIDTH)) u_axis_x (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (step),
        .val   (x),
        .wrap  (x_wrap)
    );

    scan_axis #(.MAX(Y_MAX), .WIDTH(Y_WIDTH)) u_axis_y (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (step && x_wrap),
        .val   (y),
        .wrap  (y_wrap)
    );

    // addr tracks y*(X_MAX+1)+x by counting; the final beat returns it to 0 explicitly
    always_comb begin
        addr_next = addr_reg;
        if (clr) begin
            addr_next = '0;
        end else if (step) begin
            addr_next = final_beat ? '0 : addr_reg + ADDR_ONE;
        end
    end

    // done is registered so it lands in DONE, or on the first beat of a continued sweep
    assign done_next = (state_reg == RUN) && step && final_beat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (step && final_beat) begin
                    state_next = cont_en ? RUN : DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid  = (state_reg == RUN);
        busy   = (state_reg == RUN) || (state_reg == DONE);
        last_x = valid && x_wrap;
        last_y = valid && x_wrap && y_wrap;
        done   = done_reg;
        addr   = addr_reg;
    end

endmodule
